// File: rtl/logic_pkg.sv
// Shared types and constants for the logic-op issuer and its request FIFO.
package logic_pkg;

  // Opcodes understood by the external logic unit.
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;  // NOT of operand A; B ignored

  // One queued request: {op, a, b}, 18 bits.
  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } req_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } state_e;

endpackage

// File: rtl/logic_op_issuer_if.sv
// Request, response, logic-unit and status signals of the logic-op issuer.
interface logic_op_issuer_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] req_op;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_y;
  logic       rsp_zero;
  logic [7:0] lu_a;
  logic [7:0] lu_b;
  logic [1:0] lu_s;
  logic [7:0] lu_y;
  logic       busy;
  logic [7:0] rsp_count;

  // Issuer side.
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, lu_y,
    output req_ready, rsp_valid, rsp_y, rsp_zero, lu_a, lu_b, lu_s, busy, rsp_count
  );

  // Requester / consumer / logic-unit side.
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, lu_y,
    input  req_ready, rsp_valid, rsp_y, rsp_zero, lu_a, lu_b, lu_s, busy, rsp_count
  );
endinterface

// File: rtl/logic_req_fifo.sv
// Request FIFO: DEPTH entries, read/write pointers carry an extra wrap bit.
module logic_req_fifo
  import logic_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  req_entry_t i_data,
  output req_entry_t o_data,
  output logic       o_full,
  output logic       o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  req_entry_t      r_mem [DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic            w_push_en;
  logic            w_pop_en;

  // Same index with differing wrap bits means every slot is occupied.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_en = i_push & ~o_full;
  assign w_pop_en  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since empty pointers mask them.
  always_ff @(posedge clk) begin
    if (w_push_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // Pointer update; push and pop on the same edge both advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/logic_op_issuer.sv
// Queues logic-op requests, issues them one at a time to an external logic
// unit, captures the result and holds it until the consumer accepts it.
module logic_op_issuer
  import logic_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  logic_op_issuer_if.slave bus
);
  state_e     r_state;
  state_e     w_state_next;
  req_entry_t w_fifo_wdata;
  req_entry_t w_fifo_rdata;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic       w_capture;
  logic       w_rsp_done;
  logic [7:0] r_rsp_y;
  logic       r_rsp_zero;
  logic [7:0] r_lu_a;
  logic [7:0] r_lu_b;
  logic [1:0] r_lu_s;
  logic [7:0] r_rsp_count;

  assign w_push       = bus.req_valid & ~w_full;
  assign w_fifo_wdata = '{op: bus.req_op, a: bus.req_a, b: bus.req_b};

  logic_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data (w_fifo_wdata),
    .o_data (w_fifo_rdata),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Next state plus pop / capture / completion strobes.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_rsp_done   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        w_capture    = 1'b1;
        w_state_next = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          w_rsp_done = 1'b1;
          // Chain straight into the next request to keep one result per two cycles.
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = StIssue;
          end else begin
            w_state_next = StIdle;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Operand load on pop, result capture in ISSUE, completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lu_a      <= '0;
      r_lu_b      <= '0;
      r_lu_s      <= '0;
      r_rsp_y     <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_count <= '0;
    end else begin
      if (w_pop) begin
        r_lu_a <= w_fifo_rdata.a;
        r_lu_b <= w_fifo_rdata.b;
        r_lu_s <= w_fifo_rdata.op;
      end
      if (w_capture) begin
        r_rsp_y    <= bus.lu_y;
        r_rsp_zero <= (bus.lu_y == 8'h00);
      end
      if (w_rsp_done) r_rsp_count <= r_rsp_count + 8'd1;
    end
  end

  assign bus.req_ready = ~w_full;
  assign bus.rsp_valid = (r_state == StResp);
  assign bus.rsp_y     = r_rsp_y;
  assign bus.rsp_zero  = r_rsp_zero;
  assign bus.lu_a      = r_lu_a;
  assign bus.lu_b      = r_lu_b;
  assign bus.lu_s      = r_lu_s;
  assign bus.busy      = (r_state != StIdle) | ~w_empty;
  assign bus.rsp_count = r_rsp_count;
endmodule

// File: tb/tb_logic_op_issuer.sv
// Self-checking bench for logic_op_issuer with a reference logic unit on lu_*.
module tb_logic_op_issuer;
  import logic_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic_op_issuer_if bus ();

  logic_op_issuer #(
    .DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] y;
    logic       z;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       z;
  } vec_t;

  int   n_pass   = 0;
  int   n_total  = 0;
  int   rsp_seen = 0;
  int   exp_cnt  = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic hold_pend = 1'b0;
  logic [7:0] hold_y;
  logic hold_z;
  logic rnd_done;

  function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endfunction

  // Reference logic unit driven from the registered lu_* outputs.
  always_comb bus.lu_y = ref_op(bus.lu_s, bus.lu_a, bus.lu_b);

  // Scoreboard / stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", bus.rsp_valid, 1);
        check("hold_y", bus.rsp_y, hold_y);
        check("hold_zero", bus.rsp_zero, hold_z);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_rsp: got y=%02h, required no response", bus.rsp_y);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_y", bus.rsp_y, mon_e.y);
          check("rsp_zero", bus.rsp_zero, mon_e.z);
        end
        rsp_seen++;
        exp_cnt = (exp_cnt + 1) % 256;
      end
      hold_pend = bus.rsp_valid && !bus.rsp_ready;
      hold_y    = bus.rsp_y;
      hold_z    = bus.rsp_zero;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one request until accepted (bounded), recording its expected result.
  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ey, input logic ez);
    int k = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    while (!bus.req_ready && k < 200) begin
      step();
      k++;
    end
    check("send_ready", bus.req_ready, 1);
    if (bus.req_ready) exp_q.push_back('{y: ey, z: ez});
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((bus.busy || exp_q.size() != 0) && k < 1000) begin
      step();
      k++;
    end
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_queue"}, exp_q.size(), 0);
  endtask

  // Assert reset mid-cycle, check outputs immediately, release before next edge.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_y"}, bus.rsp_y, 0);
    check({tag, "_rsp_zero"}, bus.rsp_zero, 0);
    check({tag, "_lu_a"}, bus.lu_a, 0);
    check({tag, "_lu_b"}, bus.lu_b, 0);
    check({tag, "_lu_s"}, bus.lu_s, 0);
    check({tag, "_rsp_count"}, bus.rsp_count, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    exp_q.delete();
    exp_cnt       = 0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   accepted;
    int   seen0;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [1:0] rop;
    logic saw_valid;

    vecs[0] = '{OP_AND, 8'hAA, 8'hCC, 8'h88, 1'b0};
    vecs[1] = '{OP_OR,  8'hAA, 8'hCC, 8'hEE, 1'b0};
    vecs[2] = '{OP_XOR, 8'hAA, 8'hCC, 8'h66, 1'b0};
    vecs[3] = '{OP_NOT, 8'hAA, 8'hCC, 8'h55, 1'b0};

    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;

    do_reset("rst_init");

    // Four opcodes back to back; first is offered right after reset release.
    for (int i = 0; i < 4; i++) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].z);
    wait_idle("table");
    check("table_count", bus.rsp_count, 8'd4);
    check("lu_hold_a", bus.lu_a, 8'hAA);
    check("lu_hold_b", bus.lu_b, 8'hCC);
    check("lu_hold_s", bus.lu_s, OP_NOT);

    // Zero result and two-edge latency.
    send(OP_XOR, 8'hF0, 8'hF0, 8'h00, 1'b1);
    check("lat_e0", bus.rsp_valid, 0);
    step();
    check("lat_e1", bus.rsp_valid, 0);
    step();
    check("lat_e2", bus.rsp_valid, 1);
    check("lat_y", bus.rsp_y, 8'h00);
    check("lat_zero", bus.rsp_zero, 1);
    wait_idle("lat");

    // Capacity: DEPTH queued plus one in flight.
    bus.rsp_ready = 1'b0;
    accepted      = 0;
    for (int i = 0; i < 6; i++) begin
      ra            = 8'h10 + 8'(i);
      rop           = 2'(i);
      bus.req_a     = ra;
      bus.req_b     = 8'h3C;
      bus.req_op    = rop;
      bus.req_valid = 1'b1;
      if (bus.req_ready) begin
        exp_q.push_back('{y: ref_op(rop, ra, 8'h3C), z: (ref_op(rop, ra, 8'h3C) == 8'h00)});
        accepted++;
      end
      step();
    end
    bus.req_valid = 1'b0;
    check("cap_accepted", accepted, 5);
    check("cap_req_ready", bus.req_ready, 0);
    check("cap_rsp_valid", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    wait_idle("cap");
    check("cap_ready_back", bus.req_ready, 1);
    check("cap_count", bus.rsp_count, 8'd10);

    // Random backpressure while requests stream in.
    seen0    = rsp_seen;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          ra  = 8'($urandom);
          rb  = 8'($urandom);
          rop = 2'($urandom_range(0, 3));
          send(rop, ra, rb, ref_op(rop, ra, rb), ref_op(rop, ra, rb) == 8'h00);
        end
        rnd_done = 1'b1;
      end
      begin
        int c = 0;
        while (!rnd_done && c < 5000) begin
          bus.rsp_ready = ($urandom_range(0, 1) == 1);
          step();
          c++;
        end
      end
    join
    bus.rsp_ready = 1'b1;
    wait_idle("rnd");
    check("rnd_count_seen", rsp_seen - seen0, 20);
    check("rnd_rsp_count", bus.rsp_count, 8'(exp_cnt));

    // Reset with three queued and one waiting in RESP.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(OP_OR, 8'h5A, 8'hC3, 8'hDB, 1'b0);
    check("pre_rst_valid", bus.rsp_valid, 1);
    check("pre_rst_busy", bus.busy, 1);
    do_reset("rst_mid");
    bus.rsp_ready = 1'b1;
    saw_valid     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.rsp_valid) saw_valid = 1'b1;
    end
    check("rst_no_rsp", saw_valid, 0);
    check("rst_idle", bus.busy, 0);

    // Counter wrap: 257 completions leave the counter at 1.
    for (int i = 0; i < 257; i++) begin
      ra = 8'(i);
      send(OP_XOR, ra, 8'h0F, ra ^ 8'h0F, (ra ^ 8'h0F) == 8'h00);
    end
    wait_idle("wrap");
    check("wrap_count", bus.rsp_count, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/logic_op_issuer.md
LOGIC_OP_ISSUER -- requirements
Module: logic_op_issuer

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO depth; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  request FIFO can accept (= not full).
REQ-006 req_a, req_b  input  8 each  operands.
REQ-007 req_op  input  2  opcode: 00 AND, 01 OR, 10 XOR, 11 NOT-A.
REQ-008 rsp_valid  output  1  result present.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_y  output  8  result byte.
REQ-011 rsp_zero  output  1  high when rsp_y == 0.
REQ-012 lu_a, lu_b  output  8 each  operands to the external logic unit; registered.
REQ-013 lu_s  output  2  opcode to the external logic unit; registered.
REQ-014 lu_y  input  8  combinational result from the external logic unit.
REQ-015 busy  output  1  FSM not IDLE or FIFO non-empty.
REQ-016 rsp_count  output  8  completed-response counter.

Function
REQ-017 Request SHALL be accepted on an edge with req_valid && req_ready; {req_op, req_a, req_b} pushed to FIFO.
REQ-018 req_ready SHALL be combinational !full; no push when full, no bypass path.
REQ-019 FSM states SHALL be IDLE, ISSUE, RESP.
REQ-020 IDLE: if FIFO non-empty, pop head into lu_a/lu_b/lu_s, go ISSUE; else stay.
REQ-021 ISSUE lasts exactly one cycle: capture lu_y into rsp_y, set rsp_zero = (lu_y == 0), go RESP.
REQ-022 RESP: rsp_valid = 1; rsp_y/rsp_zero SHALL hold stable until accepted.
REQ-023 RESP with rsp_ready: increment rsp_count (mod 256, 255 wraps to 0); if FIFO non-empty, pop next into lu_* and go ISSUE; else go IDLE.
REQ-024 Latency SHALL be two edges: request accepted at edge E0 into an idle, empty block gives rsp_valid high after E2.
REQ-025 Sustained throughput SHALL be one result per two cycles with rsp_ready held high.
REQ-026 Push and pop on the same edge SHALL both take effect; count unchanged.
REQ-027 rsp_valid SHALL be low in IDLE and ISSUE.
REQ-028 lu_* SHALL hold last issued values while IDLE.
REQ-029 Results SHALL be returned in request order.
REQ-030 Capacity SHALL be DEPTH queued plus one in flight.

Reset
REQ-031 rst_n low SHALL immediately force: FSM IDLE, FIFO empty, rsp_valid 0, rsp_y 0, rsp_zero 0, lu_a/lu_b/lu_s 0, rsp_count 0, busy 0, req_ready 1.
REQ-032 Reset mid-operation SHALL discard all queued and in-flight requests with no response.
REQ-033 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-034 Shared package logic_pkg SHALL hold opcode constants (OP_AND, OP_OR, OP_XOR, OP_NOT) and the 18-bit request entry type {op, a, b}.
REQ-035 FIFO SHALL be sub-module logic_req_fifo: parameter DEPTH, push/pop/full/empty, pointers with wrap bit, asynchronous active-low reset.
REQ-036 FSM, capture registers and counter SHALL reside in logic_op_issuer; no combinational path from req_* to rsp_*.

Verification
REQ-037 Bench SHALL bind lu_* to a reference logic unit and cover:
- A=AA,B=CC op 00/01/10/11 in sequence, rsp_ready=1 -> rsp_y 88, EE, 66, 55 in order; rsp_zero 0; rsp_count 4.
- A=F0,B=F0 op 10 -> rsp_y 00, rsp_zero 1; rsp_valid exactly two edges after acceptance.
- rsp_ready=0, offer 6 requests at DEPTH=4 -> 5 accepted, then req_ready 0; raising rsp_ready drains 5 responses in order, req_ready back to 1.
- rsp_ready toggled randomly during RESP -> rsp_y/rsp_zero stable while rsp_valid && !rsp_ready; no loss or duplication.
- rst_n pulsed low with 3 queued and 1 in RESP -> all outputs at reset values immediately, no further rsp_valid.
- 257 completed responses -> rsp_count reads 1.
